// File: rtl/dino_pkg.sv
// Shared constants for the HEX dinosaur game: FSM states, obstacle codes, segment patterns.
// Ports: none (package). Segment patterns are active-low {g,f,e,d,c,b,a}.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_OVER = 2'b10
    } state_e;

    localparam logic [1:0] OBS_NONE   = 2'b00;
    localparam logic [1:0] OBS_CACTUS = 2'b01;
    localparam logic [1:0] OBS_BIRD   = 2'b10;

    localparam logic [6:0] SEG_PLAYER_BOT = 7'b0100011;
    localparam logic [6:0] SEG_PLAYER_TOP = 7'b0011100;
    localparam logic [6:0] SEG_OFF        = 7'b1111111;
    localparam logic [6:0] SEG_CACTUS     = 7'b1110111;
    localparam logic [6:0] SEG_BIRD       = 7'b1111110;

    function automatic logic [6:0] obs_seg(input logic [1:0] o);
        logic [6:0] s;
        s = SEG_OFF;
        if (o == OBS_CACTUS) s = SEG_CACTUS;
        if (o == OBS_BIRD)   s = SEG_BIRD;
        return s;
    endfunction

endpackage

// File: rtl/dino_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances once per step pulse.
// Ports: clk, rst (sync, active-high), step (advance enable), q[15:0] (current state).
module dino_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        fb;

    assign fb = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

    always_comb begin
        q_d = q_q;
        if (step) q_d = {q_q[14:0], fb};
    end

    always_ff @(posedge clk) begin
        if (rst) q_q <= SEED;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// Game sequencer: tick divider, IDLE/RUN/OVER FSM, jump timer, obstacle scroller, score, HEX drive.
// Ports: CLOCK_50, RESET (sync high), jump_in (async level), spawn_force[1:0],
//        hex5..hex0[6:0] (active-low, hex5 = player), score[7:0], running, game_over.
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 12_500_000,
    parameter int unsigned JUMP_TICKS = 2,
    parameter int unsigned MIN_GAP    = 2,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       jump_in,
    input  logic [1:0] spawn_force,
    output logic [6:0] hex5,
    output logic [6:0] hex4,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic [7:0] score,
    output logic       running,
    output logic       game_over
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AIR_W = $clog2(JUMP_TICKS + 1);

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic              tick;
    logic [2:0]        jsync_q;
    logic              jedge;
    logic              pending_q, pending_d;
    logic [AIR_W-1:0]  air_q, air_d, air_nx;
    logic [5:0][1:0]   cols_q, cols_d, cols_nx;
    logic [3:0]        gap_q, gap_d, gap_nx;
    logic [7:0]        score_q, score_d, score_nx;
    logic [15:0]       lfsr_q;
    logic [12:0]       lfsr_unused;
    logic              gap_ok;
    logic              force_ok;
    logic [1:0]        spawn_t;
    logic              pend_eff;
    logic              hit;
    logic [5:0][6:0]   hex_q, hex_d;

    assign tick = (div_q == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge CLOCK_50) begin
        if (RESET || tick) div_q <= '0;
        else               div_q <= div_q + DIV_W'(1);
    end

    // [1:0] synchroniser, [2] previous synchronised level for edge detect
    always_ff @(posedge CLOCK_50) begin
        if (RESET) jsync_q <= '0;
        else       jsync_q <= {jsync_q[1], jsync_q[0], jump_in};
    end

    assign jedge = jsync_q[1] & ~jsync_q[2];

    dino_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (CLOCK_50),
        .rst  (RESET),
        .step (tick),
        .q    (lfsr_q)
    );

    assign lfsr_unused = lfsr_q[15:3];

    // Everything a RUN tick would commit, computed from current values
    always_comb begin
        gap_ok   = (32'(gap_q) >= MIN_GAP);
        force_ok = (spawn_force == 2'b01) || (spawn_force == 2'b10);
        spawn_t  = OBS_NONE;
        if (gap_ok) begin
            if (force_ok)                spawn_t = spawn_force;
            else if (lfsr_q[1:0] == 2'b11) spawn_t = lfsr_q[2] ? OBS_BIRD : OBS_CACTUS;
        end

        // a jump edge on the tick cycle itself counts for that tick
        pend_eff = pending_q | jedge;
        air_nx   = '0;
        if (pend_eff && air_q == '0) air_nx = AIR_W'(JUMP_TICKS);
        else if (air_q != '0)        air_nx = air_q - AIR_W'(1);

        cols_nx = {cols_q[4:0], spawn_t};

        hit = ((cols_nx[5] == OBS_CACTUS) && (air_nx == '0)) ||
              ((cols_nx[5] == OBS_BIRD)   && (air_nx != '0));

        gap_nx = '0;
        if (spawn_t == OBS_NONE) gap_nx = (gap_q == 4'hF) ? 4'hF : gap_q + 4'd1;

        score_nx = score_q;
        if (cols_q[5] != OBS_NONE && score_q != 8'hFF) score_nx = score_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        air_d     = air_q;
        cols_d    = cols_q;
        gap_d     = gap_q;
        score_d   = score_q;
        pending_d = tick ? 1'b0 : (pending_q | jedge);

        unique case (state_q)
            ST_IDLE: begin
                if (jedge) begin
                    state_d   = ST_RUN;
                    score_d   = '0;
                    cols_d    = '0;
                    gap_d     = '0;
                    pending_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    air_d   = air_nx;
                    cols_d  = cols_nx;
                    gap_d   = gap_nx;
                    score_d = score_nx;
                    if (hit) state_d = ST_OVER;
                end
            end
            ST_OVER: begin
                if (jedge) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            air_q     <= '0;
            cols_q    <= '0;
            gap_q     <= '0;
            score_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            air_q     <= air_d;
            cols_q    <= cols_d;
            gap_q     <= gap_d;
            score_q   <= score_d;
            pending_q <= pending_d;
        end
    end

    // Active-low AND merges the lit segments of player and obstacle
    always_comb begin
        for (int i = 0; i < 5; i++) hex_d[i] = obs_seg(cols_q[i]);
        hex_d[5] = ((air_q != '0) ? SEG_PLAYER_TOP : SEG_PLAYER_BOT) & obs_seg(cols_q[5]);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            hex_q[5] <= SEG_PLAYER_BOT;
            for (int i = 0; i < 5; i++) hex_q[i] <= SEG_OFF;
        end else begin
            hex_q <= hex_d;
        end
    end

    assign hex5      = hex_q[5];
    assign hex4      = hex_q[4];
    assign hex3      = hex_q[3];
    assign hex2      = hex_q[2];
    assign hex1      = hex_q[1];
    assign hex0      = hex_q[0];
    assign score     = score_q;
    assign running   = (state_q == ST_RUN);
    assign game_over = (state_q == ST_OVER);

endmodule
